// File: rtl/mesh_link_tx.sv
// mesh_link_tx: buffers packets in a FIFO and sends each as a header beat then a payload beat
module mesh_link_tx #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [2:0]                 enq_location,
    input  logic [4:0]                 enq_address,
    input  logic [7:0]                 enq_word,
    output logic                       link_valid,
    input  logic                       link_ready,
    output logic [7:0]                 link_data,
    output logic                       link_first,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mesh_link_tx: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t         state, next;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [15:0]    head;
    logic           push, pop;

    assign head      = mem[rp];
    assign enq_ready = count != CW'(DEPTH);
    assign push      = enq_valid & enq_ready;
    assign pop       = state == PAYLOAD && link_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= {enq_location, enq_address, enq_word};
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            state <= next;
            if (push)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        next = state;
        next = state == IDLE ? (count != '0 ? HEADER : IDLE)
             : !link_ready   ? state
             : state == HEADER ? PAYLOAD
             : (count != CW'(1) || push) ? HEADER : IDLE;
    end

    assign link_valid = state != IDLE;
    assign link_first = state == HEADER;
    assign link_data  = state == HEADER ? head[15:8] : state == PAYLOAD ? head[7:0] : 8'h00;
    assign busy       = state != IDLE || count != '0;
endmodule
